// File: rtl/aes_pkg.sv
// Shared types for the AES job feeder: job record, feeder FSM states and block width.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef struct packed {
    logic [AES_BLOCK_W-1:0] pt;
    logic [AES_BLOCK_W-1:0] key;
  } aes_job_t;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } feeder_state_e;

endpackage

// File: rtl/aes_job_fifo.sv
// Circular job FIFO (DEPTH x aes_job_t) with occupancy count and full/empty flags.
// The caller only pushes while not full; pops on empty are ignored.
module aes_job_fifo
  import aes_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  aes_job_t      wdata,
  input  logic          pop,
  output aes_job_t      rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  aes_job_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign rdata  = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_pop)      count <= count + 1'b1;
      else if (!push && do_pop) count <= count - 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  push_not_full: assert property (@(posedge clk) disable iff (!rstn) push |-> (count < FULL_CNT));

endmodule

// File: rtl/aes_job_feeder.sv
// Feeds (plain_text, cipher_key) jobs into the N-slowed AES core and gates done into res_valid.
// Optional AES_FEEDER_STATS_EN adds saturating job_cnt / bubble_cnt outputs.
module aes_job_feeder
  import aes_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_plain_text,
  input  logic [AES_BLOCK_W-1:0] in_cipher_key,
  output logic                   start,
  output logic [AES_BLOCK_W-1:0] plain_text,
  output logic [AES_BLOCK_W-1:0] cipher_key,
  input  logic                   done,
  output logic                   res_valid
`ifdef AES_FEEDER_STATS_EN
  ,
  output logic [31:0]            job_cnt,
  output logic [31:0]            bubble_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(N);

  feeder_state_e state;
  logic [PW-1:0] prime_cnt;
  logic [N-1:0]  tags;       // one bit per in-flight core slot, 1 = bubble, [0] is oldest
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          consume;
  logic          push;
  logic          pop;
  aes_job_t      head;
  aes_job_t      in_job;

  assign in_job.pt  = in_plain_text;
  assign in_job.key = in_cipher_key;

  // The core captures its inputs on every consume edge and cannot be stalled.
  assign consume    = start && ((state == PRIME) || done);
  assign push       = in_valid && in_ready;
  assign pop        = consume && !empty;
  assign in_ready   = !full;
  assign plain_text = empty ? '0 : head.pt;
  assign cipher_key = empty ? '0 : head.key;
  assign res_valid  = done && (state == RUN) && !tags[0];

  aes_job_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata (in_job),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      start     <= 1'b0;
      prime_cnt <= '0;
      tags      <= '0;
    end else begin
      // In RUN every consume coincides with a done, so the shift both retires and refills a slot.
      if (consume) tags <= {empty, tags[N-1:1]};
      case (state)
        IDLE: begin
          if (count >= CW'(N)) begin
            state     <= PRIME;
            start     <= 1'b1;
            prime_cnt <= '0;
          end
        end
        PRIME: begin
          if (consume) begin
            if (prime_cnt == PW'(N-1)) state <= RUN;
            else                       prime_cnt <= prime_cnt + 1'b1;
          end
        end
        RUN:     ;
        default: begin
          state <= IDLE;
          start <= 1'b0;
        end
      endcase
    end
  end

`ifdef AES_FEEDER_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      job_cnt    <= '0;
      bubble_cnt <= '0;
    end else if (consume) begin
      if (!empty && (job_cnt != '1))   job_cnt    <= job_cnt + 1'b1;
      if (empty && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`endif

endmodule
